// File: rtl/code_pkg.sv
// Shared types for the code matcher: FSM state encoding and the fail-counter helper.
package code_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    RESULT = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int FAIL_W = 4;

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] cnt,
                                                input logic [FAIL_W-1:0] max);
    sat_inc = (cnt >= max) ? max : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/code_matcher_eq.sv
// WIDTH-parameterised equality comparator used for the per-symbol check.
module code_matcher_eq #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule

// File: rtl/code_matcher.sv
// Code matcher: stores a DEPTH-symbol reference code, compares entered sequences
// against it and locks out after MAX_TRIES consecutive failed entries.
module code_matcher
  import code_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     clear,
  output logic                     match,
  output logic                     mismatch,
  output logic                     locked,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int                IW       = $clog2(DEPTH);
  localparam logic [IW-1:0]     LAST_IDX = IW'(DEPTH - 1);
  localparam logic [FAIL_W-1:0] MAX_F    = FAIL_W'(MAX_TRIES);

  state_t                state_r, state_nxt;
  logic [IW-1:0]         idx_r, idx_nxt;
  logic [IW-1:0]         wr_ptr_r;
  logic [FAIL_W-1:0]     fail_r, fail_nxt;
  logic                  all_eq_r, all_eq_nxt;
  logic                  match_r, match_nxt;
  logic                  mismatch_r, mismatch_nxt;
  logic                  active_r;
  logic [WIDTH-1:0]      ref_r [DEPTH];
  logic                  sym_eq_s;
  logic                  eq_acc_s;
  logic                  in_ready_s;
  logic                  load_ready_s;
  logic                  accept_s;
  logic                  load_acc_s;

  // active_r keeps both ready outputs low until the first clock edge after reset release
  assign in_ready_s   = active_r & ((state_r == IDLE) | (state_r == CMP));
  assign load_ready_s = active_r & (state_r == IDLE) & ~in_valid;
  assign accept_s     = in_valid & in_ready_s;
  assign load_acc_s   = load_valid & load_ready_s;

  code_matcher_eq #(.WIDTH(WIDTH)) u_eq (
    .a  (in_data),
    .b  (ref_r[idx_r]),
    .eq (sym_eq_s)
  );

  // Next-state, compare accumulation and result-pulse decision
  always_comb begin
    state_nxt    = state_r;
    idx_nxt      = idx_r;
    all_eq_nxt   = all_eq_r;
    fail_nxt     = fail_r;
    match_nxt    = 1'b0;
    mismatch_nxt = 1'b0;
    eq_acc_s     = 1'b0;
    if (clear) begin
      state_nxt  = IDLE;
      idx_nxt    = {IW{1'b0}};
      all_eq_nxt = 1'b0;
      fail_nxt   = {FAIL_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, CMP: begin
          if (accept_s) begin
            // the first symbol of a sequence starts from a fresh all-equal flag
            eq_acc_s   = ((idx_r == {IW{1'b0}}) ? 1'b1 : all_eq_r) & sym_eq_s;
            all_eq_nxt = eq_acc_s;
            if (idx_r == LAST_IDX) begin
              state_nxt    = RESULT;
              idx_nxt      = {IW{1'b0}};
              match_nxt    = eq_acc_s;
              mismatch_nxt = ~eq_acc_s;
              fail_nxt     = eq_acc_s ? {FAIL_W{1'b0}} : sat_inc(fail_r, MAX_F);
            end else begin
              state_nxt = CMP;
              idx_nxt   = idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
          end else begin
            state_nxt = state_r;
          end
        end
        RESULT: begin
          if (fail_r >= MAX_F) begin
            state_nxt = LOCKED;
          end else begin
            state_nxt = IDLE;
          end
        end
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= {IW{1'b0}};
      fail_r     <= {FAIL_W{1'b0}};
      all_eq_r   <= 1'b1;
      match_r    <= 1'b0;
      mismatch_r <= 1'b0;
      active_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      idx_r      <= idx_nxt;
      fail_r     <= fail_nxt;
      all_eq_r   <= all_eq_nxt;
      match_r    <= match_nxt;
      mismatch_r <= mismatch_nxt;
      active_r   <= 1'b1;
    end
  end

  // Reference store with a wrapping write pointer; clear leaves it intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {IW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ref_r[i] <= {WIDTH{1'b0}};
      end
    end else if (load_acc_s) begin
      ref_r[wr_ptr_r] <= load_data;
      wr_ptr_r        <= (wr_ptr_r == LAST_IDX) ? {IW{1'b0}}
                                                : wr_ptr_r + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  assign load_ready = load_ready_s;
  assign in_ready   = in_ready_s;
  assign match      = match_r;
  assign mismatch   = mismatch_r;
  assign locked     = (state_r == LOCKED);
  assign idx        = idx_r;

endmodule
